pwm_dac: RTL and testbench
==========================

PWM_DAC -- requirements
Module: pwm_dac

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning code width; the PWM period is 2^WIDTH clk cycles.
REQ-002 SHALL provide parameter SETTLE_PERIODS, default 16, meaning the number of full PWM periods after a code change before settled asserts; legal range 1 to 65535.
REQ-003 SHALL provide port clk, input, 1, system clock; all logic is on its rising edge.
REQ-004 SHALL provide port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL provide port code_in, input, WIDTH, requested DAC code (SAR trial code).
REQ-006 SHALL provide port code_load, input, 1, strobe that captures code_in as the pending code.
REQ-007 SHALL provide port pwm_out, output, 1, registered PWM waveform driving the external RC filter.
REQ-008 SHALL provide port period_start, output, 1, one-cycle pulse at the first cycle of each PWM period.
REQ-009 SHALL provide port active_code, output, WIDTH, the code currently being generated.
REQ-010 SHALL provide port settled, output, 1, high when the filtered analog level is valid for active_code.

Function
REQ-011 SHALL run a free WIDTH-bit period counter cnt that increments every cycle and wraps from 2^WIDTH-1 to 0.
REQ-012 SHALL drive pwm_out on the cycle after cnt=k to the value (k < active_code); one-cycle registered latency; code 0 gives constant low; code 2^WIDTH-1 gives high for 2^WIDTH-1 of 2^WIDTH cycles.
REQ-013 SHALL, on code_load=1, latch code_in into pending_code and set pending; with several loads in one period, the last one wins.
REQ-014 SHALL update active_code only at the period boundary: on the cycle where cnt=2^WIDTH-1, if pending=1, active_code is set to pending_code and pending is cleared.
REQ-015 SHALL, when code_load=1 on the boundary cycle itself, apply that cycle's code_in directly at that boundary; pending ends cleared.
REQ-016 SHALL never change duty mid-period (glitch-free); each period reflects exactly one active_code.
REQ-017 SHALL assert period_start for exactly one cycle whenever cnt=0.
REQ-018 SHALL implement a settle FSM with the states below.
- S_IDLE: after reset, until the first boundary.
- S_SETTLING: counting full periods.
- S_SETTLED: settled=1.
REQ-019 SHALL transition from S_IDLE to S_SETTLING at the first boundary, with settle_cnt=0.
REQ-020 SHALL, in S_SETTLING, increment settle_cnt at each boundary and transition to S_SETTLED when settle_cnt reaches SETTLE_PERIODS.
REQ-021 SHALL, in S_SETTLING or S_SETTLED, return to S_SETTLING with settle_cnt=0 at any boundary where active_code changes value; applying an identical code leaves the state unchanged.
REQ-022 SHALL drop settled on the cycle after a code_load whose value differs from active_code or from the pending value (early invalidation).
REQ-023 SHALL keep settle_cnt at ceil(log2(SETTLE_PERIODS+1)) bits and saturate it at its maximum.

Reset
REQ-024 SHALL, with reset=1 at a clock edge, set the following on the same edge.
- cnt=0, pending=0, pending_code=0, active_code=0.
- pwm_out=0, period_start=0, settled=0.
- State S_IDLE.
REQ-025 SHALL, on reset mid-period or mid-settle, abandon the period with no partial update of active_code.
REQ-026 SHALL ignore code_load while reset=1.

Configuration
REQ-027 SHALL, with macro PWM_DAC_SETTLE_EN defined, compile in the settle FSM and counter, with settled behaving as in REQ-018 to REQ-023.
REQ-028 SHALL, without PWM_DAC_SETTLE_EN, omit the settle FSM and counter; settled is then 1 in every cycle where pending=0 and no boundary update occurred on the previous cycle, 0 otherwise, and 0 during reset.

Verification (WIDTH=8, SETTLE_PERIODS=4, macro defined unless noted)
REQ-029 SHALL cover the duty test: load 0x40 then wait one boundary -> pwm_out high for exactly 64 of 256 cycles in each period; code 0x00 -> pwm_out always low; code 0xFF -> 255 high cycles.
REQ-030 SHALL cover mid-period loads: load 0x10 at cnt=20, then 0x80 at cnt=100 -> active_code stays at its old value until cnt wraps, then becomes 0x80; 0x10 is never applied.
REQ-031 SHALL cover a boundary-cycle load: code_load with 0x33 at cnt=255 -> active_code=0x33 in the next cycle; pending=0.
REQ-032 SHALL cover settle timing: load 0x55 -> settled=0, then settled=1 after the 4th boundary following the update; reloading 0x55 -> settled stays 1; loading 0x56 -> settled=0 on the next cycle.
REQ-033 SHALL cover reset: assert reset at cnt=150 with active_code=0x90 -> next cycle all outputs 0 and cnt=0; after release, period_start pulses 1 cycle later.
REQ-034 SHALL cover the macro-undefined build: load 0x20 -> settled=0 until the boundary update, then settled=1 from the second cycle after it.

Source files
------------

// File: rtl/pwm_dac.sv
// rtl/pwm_dac.sv - glitch-free PWM DAC with period-aligned code update and settle tracking
// Optional settle FSM/counter compiled in with macro PWM_DAC_SETTLE_EN.
module pwm_dac #(
    parameter int WIDTH          = 8,
    parameter int SETTLE_PERIODS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] code_in,
    input  logic             code_load,
    output logic             pwm_out,
    output logic             period_start,
    output logic [WIDTH-1:0] active_code,
    output logic             settled
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] pending_code;
    logic             pending;
    logic             boundary;
    logic [WIDTH-1:0] next_code;
    logic             apply;

    // Last cycle of a period: the only point where active_code may change.
    assign boundary = (cnt == CNT_MAX);

    // Code for the next period: a load on the boundary cycle beats the pending one.
    always_comb begin
        next_code = active_code;
        apply     = 1'b0;
        if (boundary) begin
            if (code_load) begin
                next_code = code_in;
                apply     = 1'b1;
            end else if (pending) begin
                next_code = pending_code;
                apply     = 1'b1;
            end
        end
    end

    // Free-running period counter, registered comparator and period marker.
    // period_start shares pwm_out's one-cycle latency so it flags the first output cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt + 1'b1;
            pwm_out      <= (cnt < active_code);
            period_start <= (cnt == '0);
        end
    end

    // Pending/active code registers; active_code only moves on the boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending      <= 1'b0;
            pending_code <= '0;
            active_code  <= '0;
        end else if (boundary) begin
            active_code <= next_code;
            pending     <= 1'b0;
            if (code_load) begin
                pending_code <= code_in;
            end
        end else if (code_load) begin
            pending_code <= code_in;
            pending      <= 1'b1;
        end
    end

`ifdef PWM_DAC_SETTLE_EN

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLING,
        S_SETTLED
    } settle_state_t;

    localparam int             SCW        = $clog2(SETTLE_PERIODS + 1);
    localparam logic [SCW-1:0] SETTLE_TGT = SCW'(SETTLE_PERIODS);
    localparam logic [SCW-1:0] SCNT_MAX   = '1;

    settle_state_t  state;
    settle_state_t  state_next;
    logic [SCW-1:0] settle_cnt;
    logic [SCW-1:0] settle_cnt_next;
    logic [SCW-1:0] settle_inc;
    logic           code_changed;
    logic           early_inval;

    assign code_changed = apply && (next_code != active_code);
    // A load that would change the output level invalidates the settled flag right away.
    assign early_inval  = code_load &&
                          ((code_in != active_code) || (pending && (code_in != pending_code)));
    assign settle_inc   = (settle_cnt == SCNT_MAX) ? settle_cnt : settle_cnt + 1'b1;
    assign settled      = (state == S_SETTLED);

    // Settle FSM state and period counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_cnt_next;
        end
    end

    // Settle FSM next-state: count unchanged periods, restart on any code change.
    always_comb begin
        state_next      = state;
        settle_cnt_next = settle_cnt;
        case (state)
            S_IDLE: begin
                if (boundary) begin
                    state_next      = S_SETTLING;
                    settle_cnt_next = '0;
                end
            end
            S_SETTLING: begin
                if (boundary) begin
                    if (code_changed) begin
                        settle_cnt_next = '0;
                    end else begin
                        settle_cnt_next = settle_inc;
                        if (settle_inc >= SETTLE_TGT) begin
                            state_next = S_SETTLED;
                        end
                    end
                end else if (early_inval) begin
                    settle_cnt_next = '0;
                end
            end
            S_SETTLED: begin
                if ((boundary && code_changed) || (!boundary && early_inval)) begin
                    state_next      = S_SETTLING;
                    settle_cnt_next = '0;
                end
            end
            default: begin
                state_next      = S_IDLE;
                settle_cnt_next = '0;
            end
        endcase
    end

`else

    logic upd_q;
    logic unused_settle_cfg;

    assign unused_settle_cfg = (SETTLE_PERIODS > 0);

    // Remember that the previous cycle applied a new code at the boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            upd_q <= 1'b0;
        end else begin
            upd_q <= apply;
        end
    end

    assign settled = !reset && !pending && !upd_q;

`endif

endmodule

// File: tb/tb_pwm_dac.sv
// tb/tb_pwm_dac.sv - scoreboard bench for pwm_dac (WIDTH=8, SETTLE_PERIODS=4)
module tb_pwm_dac;

    logic       clk;
    logic       reset;
    logic [7:0] code_in;
    logic       code_load;
    logic       pwm_out;
    logic       period_start;
    logic [7:0] active_code;
    logic       settled;

    pwm_dac #(
        .WIDTH         (8),
        .SETTLE_PERIODS(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .code_in     (code_in),
        .code_load   (code_load),
        .pwm_out     (pwm_out),
        .period_start(period_start),
        .active_code (active_code),
        .settled     (settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        int code;
        int highs;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    logic [7:0] tb_cnt = '0;
    int         tb_per = 0;

`ifdef PWM_DAC_SETTLE_EN
    localparam bit SETTLE_EN = 1'b1;
`else
    localparam bit SETTLE_EN = 1'b0;
`endif

    // Bench-side period position, used to time stimulus.
    always @(posedge clk) begin
        if (reset) begin
            tb_cnt <= '0;
            tb_per <= 0;
        end else begin
            tb_cnt <= tb_cnt + 8'd1;
            if (tb_cnt == 8'hFF) tb_per <= tb_per + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_at(input int per, input int c);
        int n;
        n = 0;
        while (!(tb_per == per && int'(tb_cnt) == c)) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                n_checks++;
                n_err++;
                $display("FAIL wait_timeout actual=%0d/%0d expected=%0d/%0d", tb_per, tb_cnt, per, c);
                return;
            end
        end
    endtask

    task automatic load(input int per, input int c, input logic [7:0] code);
        wait_at(per, c);
        code_in   = code;
        code_load = 1'b1;
        @(negedge clk);
        code_load = 1'b0;
    endtask

    task automatic push(input int id, input int code, input int highs);
        exp_t e;
        e.id    = id;
        e.code  = code;
        e.highs = highs;
        sb_q.push_back(e);
    endtask

    // Monitor: count pwm_out highs per output period and score each finished period.
    int highs    = 0;
    int cur_win  = 0;
    int next_win = 0;
    int code_st  = 0;
    bit in_win   = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_win   = 1'b0;
                next_win = 0;
            end else if (period_start) begin
                if (in_win) begin
                    while (sb_q.size() > 0 && sb_q[0].id < cur_win) begin
                        e = sb_q.pop_front();
                        chk("sb_missed_period", cur_win, e.id);
                    end
                    if (sb_q.size() > 0 && sb_q[0].id == cur_win) begin
                        e = sb_q.pop_front();
                        chk($sformatf("sb_code_p%0d", cur_win), code_st, e.code);
                        chk($sformatf("sb_highs_p%0d", cur_win), highs, e.highs);
                    end
                end
                cur_win  = next_win;
                next_win = next_win + 1;
                in_win   = 1'b1;
                highs    = int'(pwm_out);
                code_st  = int'(active_code);
            end else if (in_win) begin
                highs = highs + int'(pwm_out);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        code_in   = '0;
        code_load = 1'b0;

        // Expected period table: {period, active_code, high cycles}.
        push(0,  8'h00, 0);
        push(1,  8'h40, 64);
        push(2,  8'h40, 64);
        push(3,  8'h40, 64);
        push(4,  8'h80, 128);
        push(5,  8'h33, 51);
        push(6,  8'h33, 51);
        push(7,  8'hFF, 255);
        push(8,  8'h00, 0);
        push(9,  8'h55, 85);
        push(10, 8'h55, 85);
        push(11, 8'h55, 85);
        push(12, 8'h55, 85);
        push(13, 8'h55, 85);
        push(14, 8'h55, 85);
        push(15, 8'h56, 86);
        push(16, 8'h20, 32);

        repeat (3) @(negedge clk);
        code_in   = 8'hAA;
        code_load = 1'b1;
        @(negedge clk);
        code_load = 1'b0;
        chk("rst_pwm_out", pwm_out, 0);
        chk("rst_period_start", period_start, 0);
        chk("rst_active_code", active_code, 0);
        chk("rst_settled", settled, 0);
        reset = 1'b0;

        load(0, 10, 8'h40);

        load(3, 20, 8'h10);
        load(3, 100, 8'h80);
        wait_at(3, 200);
        chk("mid_hold_200", active_code, 8'h40);
        wait_at(3, 255);
        chk("mid_hold_255", active_code, 8'h40);
        wait_at(4, 0);
        chk("mid_apply", active_code, 8'h80);

        load(4, 255, 8'h33);
        chk("bnd_apply", active_code, 8'h33);

        load(6, 5, 8'hFF);
        load(7, 5, 8'h00);
        load(8, 5, 8'h55);

        wait_at(12, 255);
        chk("settle_before_4th", settled, SETTLE_EN ? 0 : 1);
        wait_at(13, 0);
        chk("settle_after_4th", settled, 1);
        load(13, 10, 8'h55);
        chk("settle_reload_same", settled, SETTLE_EN ? 1 : 0);
        wait_at(14, 0);
        chk("settle_same_bnd", settled, SETTLE_EN ? 1 : 0);
        load(14, 30, 8'h56);
        chk("settle_early_inval", settled, 0);

        load(15, 40, 8'h20);
        chk("s20_after_load", settled, 0);
        wait_at(15, 255);
        chk("s20_bnd_cycle", settled, 0);
        wait_at(16, 0);
        chk("s20_upd_plus1", settled, 0);
        @(negedge clk);
        chk("s20_upd_plus2", settled, SETTLE_EN ? 0 : 1);
        @(negedge clk);
        chk("s20_upd_plus3", settled, SETTLE_EN ? 0 : 1);

        load(16, 5, 8'h90);
        wait_at(17, 1);
        chk("pre_rst_active", active_code, 8'h90);
        wait_at(17, 150);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_pwm_out", pwm_out, 0);
        chk("mid_rst_period_start", period_start, 0);
        chk("mid_rst_active_code", active_code, 0);
        chk("mid_rst_settled", settled, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_pstart_hi", period_start, 1);
        @(negedge clk);
        chk("post_rst_pstart_lo", period_start, 0);
        chk("post_rst_active", active_code, 0);

        push(0, 8'h00, 0);
        wait_at(1, 2);
        chk("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
